pipe_hazard_ctrl: RTL

//  Central pipeline control unit for the RISC-V core: merges jump, load-use, multi-cycle hold
//  and bus-wait requests into per-stage stall/flush vectors and the redirect to the PC stage.

---
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control: folds bus-wait, multi-cycle hold, jump and load-use requests into
// per-stage stall/flush vectors and the PC redirect, with a pending-jump slot and post-jump drain.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES   = 6,
  parameter int ADDR_W       = 32,
  parameter int JUMP_DEPTH   = 3,
  parameter int EX_IDX       = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_jump_flag,
  input  logic [ADDR_W-1:0]     i_jump_addr,
  input  logic                  i_load_use,
  input  logic                  i_hold_req,
  input  logic                  i_bus_wait,
  output logic                  o_ctrl_jump_flag,
  output logic [ADDR_W-1:0]     o_ctrl_jump_addr,
  output logic [NUM_STAGES-1:0] o_stall,
  output logic [NUM_STAGES-1:0] o_flush,
  output logic                  o_busy
);

  localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  localparam logic [NUM_STAGES-1:0] ALL_ONES   = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] JUMP_STALL = ALL_ONES >> (NUM_STAGES - JUMP_DEPTH);
  localparam logic [NUM_STAGES-1:0] HOLD_STALL = ALL_ONES >> (NUM_STAGES - 1 - EX_IDX);
  localparam logic [NUM_STAGES-1:0] LU_STALL   = ALL_ONES >> (NUM_STAGES - 3);
  localparam logic [NUM_STAGES:0]   HOLD_FULL  = (NUM_STAGES+1)'(1) << (EX_IDX + 1);
  localparam logic [NUM_STAGES-1:0] HOLD_FLUSH = HOLD_FULL[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] IF_FLUSH   = NUM_STAGES'(2);
  localparam logic [NUM_STAGES-1:0] EX_FLUSH   = NUM_STAGES'(8);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pend_addr, w_pend_addr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

  logic                w_blocked;
  logic                w_issue;
  logic                w_jump_flag;
  logic [ADDR_W-1:0]   w_jump_addr;
  logic [NUM_STAGES-1:0] w_stall, w_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RUN;
      r_pend_addr <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign w_blocked = i_bus_wait | i_hold_req;
  // A captured jump beats any new request; in PEND a fresh jump_flag is ignored.
  assign w_issue   = !w_blocked && ((r_state == PEND) || i_jump_flag);

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_addr_nxt = r_pend_addr;
    w_cnt_nxt       = r_cnt;
    w_stall         = '0;
    w_flush         = '0;
    w_jump_flag     = 1'b0;
    w_jump_addr     = '0;

    if (i_bus_wait) begin
      w_stall = ALL_ONES;
    end else if (i_hold_req) begin
      w_stall = HOLD_STALL;
      w_flush = HOLD_FLUSH;
    end else if (w_issue) begin
      w_jump_flag = 1'b1;
      w_jump_addr = (r_state == PEND) ? r_pend_addr : i_jump_addr;
      w_stall     = JUMP_STALL;
    end else if (r_state == DRAIN) begin
      w_flush = IF_FLUSH;
    end else if (i_load_use) begin
      w_stall = LU_STALL;
      w_flush = EX_FLUSH;
    end

    if (w_blocked) begin
      if (r_state != PEND && i_jump_flag) begin
        w_state_nxt     = PEND;
        w_pend_addr_nxt = i_jump_addr;
      end
    end else if (w_issue) begin
      if (FLUSH_CYCLES > 0) begin
        w_state_nxt = DRAIN;
        w_cnt_nxt   = CNT_W'(FLUSH_CYCLES);
      end else begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    end else if (r_state == DRAIN) begin
      if (r_cnt <= CNT_W'(1)) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end
  end

  // Outputs are forced quiet for the whole reset interval, not just after the first edge.
  always_comb begin
    o_ctrl_jump_flag = 1'b0;
    o_ctrl_jump_addr = '0;
    o_stall          = '0;
    o_flush          = '0;
    o_busy           = 1'b0;
    if (i_rst_n) begin
      o_ctrl_jump_flag = w_jump_flag;
      o_ctrl_jump_addr = w_jump_addr;
      o_stall          = w_stall;
      o_flush          = w_flush;
      o_busy           = (r_state != RUN);
    end
  end

endmodule
